multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multicycle MIPS control unit that sequences the shared datapath (PC, instruction register, register file, single ALU, unified memory) through fetch, decode, execute, memory and write-back states. It replaces the two-state bring-up controller and drives the PC control signals, IR load and ALU selector, plus the memory, register-file and mux controls. It waits on a memory ready handshake, so memory latency is variable.

## Interface
- No parameters.
- Clk  in  1  clock, rising edge.
- Reset_PC  in  1  reset, asynchronous, active-low.
- Opcode  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- Mem_Ready  in  1  memory completed the access this cycle.
- Load_PC, Empty_PC, IRWrite  out  1 each  PC load, PC clear, IR load.
- Seletor_ULA  out  3  ALU op: 000 nop, 001 add, 010 sub, 011 and, 100 or, 101 slt.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- IorD, MemRead, MemWrite, Load_MDR  out  1 each  memory address select (1 = ALUOut), memory read, memory write, MDR load.
- Load_A, Load_B, Load_ALUOut  out  1 each  register loads.
- RegDst, RegWrite, MemtoReg  out  1 each  register-file controls.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = trap vector.
- Exception  out  1  illegal-opcode trap pulse.
- State_Out  out  4  current state code, for debug.

## Operation
- States and codes: RST 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, ADDI_EXEC 11, ADDI_WB 12, TRAP 13.
- Every output is 0 unless it is listed for the current state.
- RST: Empty_PC=1. Next state is FETCH.
- FETCH: MemRead=1, IorD=0.
  - If Mem_Ready: IRWrite=1, ALUSrcA=0, ALUSrcB=01, Seletor_ULA=001, PCSource=00, Load_PC=1, next state DECODE.
  - Otherwise: stay in FETCH.
- DECODE: Load_A=1, Load_B=1, ALUSrcA=0, ALUSrcB=11, Seletor_ULA=001, Load_ALUOut=1. Next state by Opcode:
  - 0x00 → R_EXEC
  - 0x23 or 0x2B → MEM_ADDR
  - 0x04 → BRANCH
  - 0x02 → JUMP
  - 0x08 → ADDI_EXEC
  - any other value → see Configuration.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, Seletor_ULA=001, Load_ALUOut=1. Next state MEM_READ for 0x23, MEM_WRITE for 0x2B.
- MEM_READ: MemRead=1, IorD=1. On Mem_Ready: Load_MDR=1, next state MEM_WB. Otherwise stay.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. On Mem_Ready go to FETCH. Otherwise stay.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, Load_ALUOut=1. Seletor_ULA from Funct: 0x20 → 001, 0x22 → 010, 0x24 → 011, 0x25 → 100, 0x2A → 101, any other → 000. Next state R_WB.
- R_WB: RegDst=1, MemtoReg=0. RegWrite=1 only if Funct is supported. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, Seletor_ULA=010, PCSource=01. Load_PC=Zero (Mealy output). Next state FETCH.
- JUMP: PCSource=10, Load_PC=1. Next state FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, Seletor_ULA=001, Load_ALUOut=1. Next state ADDI_WB.
- ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1. Next state FETCH.
- Opcode and Funct are sampled only after IRWrite, so the IR holds them stable.

## Timing
- State register is updated on the rising edge of Clk.
- Outputs are combinational from state. Exceptions: outputs qualified by Mem_Ready or Zero are also combinational from those inputs.
- Reset_PC low: state goes to RST immediately, asynchronously, from any state including mid-access. All outputs take RST values, so Empty_PC=1 and MemWrite=0 at once.
- First rising edge after Reset_PC goes high moves the FSM to FETCH.
- Cycles per instruction with Mem_Ready held high:
  - R-type, sw, addi: 4
  - lw: 5
  - beq, j: 3
- Each cycle with Mem_Ready low adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- Mem_Ready is ignored in every other state.
- MemRead and MemWrite stay asserted for the whole wait and drop the cycle after the Mem_Ready cycle.

## Configuration
- Macro: MULTICYCLE_CTRL_ILLEGAL_OP_TRAP_EN.
- Defined: an unsupported Opcode in DECODE goes to TRAP. TRAP lasts one cycle with Exception=1, PCSource=11, Load_PC=1, then FETCH.
- Undefined: an unsupported Opcode in DECODE goes straight to FETCH, acting as a NOP. Exception is tied to 0 and state 13 is unreachable.

## Test plan
- Reset: Reset_PC low mid-MEM_WRITE → State_Out=0, Empty_PC=1, MemWrite=0 immediately. After release, next edge → State_Out=1.
- R-type add (Opcode 0x00, Funct 0x20), Mem_Ready=1 → states 1,2,7,8,1. Seletor_ULA=001 in R_EXEC. RegWrite=1, RegDst=1 in R_WB.
- lw (0x23) with Mem_Ready low for 2 cycles in MEM_READ → states 1,2,3,4,4,4,5,1. Load_MDR=1 only in the third MEM_READ cycle.
- beq (0x04): Zero=1 → Load_PC=1, PCSource=01 in BRANCH. Zero=0 → Load_PC=0. Both cases return to FETCH.
- Fetch stall: Mem_Ready low for 3 cycles → FETCH held 4 cycles. IRWrite and Load_PC pulse once, together.
- Opcode 0x3F: with macro → state 13, Exception=1, PCSource=11 for one cycle. Without macro → DECODE then FETCH, Exception=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/write-back with a memory ready handshake.
// Optional MULTICYCLE_CTRL_ILLEGAL_OP_TRAP_EN: an unsupported opcode traps to the vector instead of acting as a NOP.
module multicycle_ctrl (
  input  logic       Clk,
  input  logic       Reset_PC,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Mem_Ready,
  output logic       Load_PC,
  output logic       Empty_PC,
  output logic       IRWrite,
  output logic [2:0] Seletor_ULA,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Load_MDR,
  output logic       Load_A,
  output logic       Load_B,
  output logic       Load_ALUOut,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic [1:0] PCSource,
  output logic       Exception,
  output logic [3:0] State_Out
);

  typedef enum logic [3:0] {
    S_RST       = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state, next_state;
  logic [2:0] r_alu;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_PC) begin
    if (!Reset_PC) state <= S_RST;
    else           state <= next_state;
  end

  // Unsupported Funct maps to NOP; a nonzero code doubles as "supported".
  always_comb begin
    case (Funct)
      6'h20:   r_alu = ALU_ADD;
      6'h22:   r_alu = ALU_SUB;
      6'h24:   r_alu = ALU_AND;
      6'h25:   r_alu = ALU_OR;
      6'h2A:   r_alu = ALU_SLT;
      default: r_alu = ALU_NOP;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    next_state  = state;
    Load_PC     = 1'b0;
    Empty_PC    = 1'b0;
    IRWrite     = 1'b0;
    Seletor_ULA = ALU_NOP;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Load_MDR    = 1'b0;
    Load_A      = 1'b0;
    Load_B      = 1'b0;
    Load_ALUOut = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    PCSource    = 2'b00;
    Exception   = 1'b0;
    case (state)
      S_RST: begin
        Empty_PC   = 1'b1;
        next_state = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        if (Mem_Ready) begin
          IRWrite     = 1'b1;
          ALUSrcB     = 2'b01;
          Seletor_ULA = ALU_ADD;
          Load_PC     = 1'b1;
          next_state  = S_DECODE;
        end
      end
      S_DECODE: begin
        Load_A      = 1'b1;
        Load_B      = 1'b1;
        ALUSrcB     = 2'b11;
        Seletor_ULA = ALU_ADD;
        Load_ALUOut = 1'b1;
        case (Opcode)
          OP_R:         next_state = S_R_EXEC;
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDI_EXEC;
`ifdef MULTICYCLE_CTRL_ILLEGAL_OP_TRAP_EN
          default:      next_state = S_TRAP;
`else
          default:      next_state = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        Seletor_ULA = ALU_ADD;
        Load_ALUOut = 1'b1;
        next_state  = (Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (Mem_Ready) begin
          Load_MDR   = 1'b1;
          next_state = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (Mem_Ready) next_state = S_FETCH;
      end
      S_R_EXEC: begin
        ALUSrcA     = 1'b1;
        Load_ALUOut = 1'b1;
        Seletor_ULA = r_alu;
        next_state  = S_R_WB;
      end
      S_R_WB: begin
        RegDst     = 1'b1;
        RegWrite   = |r_alu;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        Seletor_ULA = ALU_SUB;
        PCSource    = 2'b01;
        Load_PC     = Zero;
        next_state  = S_FETCH;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        Load_PC    = 1'b1;
        next_state = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        Seletor_ULA = ALU_ADD;
        Load_ALUOut = 1'b1;
        next_state  = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_OP_TRAP_EN
      S_TRAP: begin
        Exception  = 1'b1;
        PCSource   = 2'b11;
        Load_PC    = 1'b1;
        next_state = S_FETCH;
      end
`endif
      default: next_state = S_RST;
    endcase
  end

  assign State_Out = state;

endmodule
